sa_result_drain: RTL and testbench

Downstream stage of the 4x4 systolic array. Captures the four 128-bit result rows (16 x 32-bit accumulators) when the array signals completion, then streams them out as sixteen 32-bit beats on a valid/ready stream toward the user-project output path/DMA. Gives the controller a busy indication and an overrun flag so a new tile is never silently merged with an undrained one.

---
 rtl/sa_result_drain.sv | 142 ++++++++++++++
 tb/tb_sa_result_drain.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_drain.sv
// sa_result_drain: captures a finished 4x4 systolic-array tile and streams
// its sixteen 32-bit results out one beat at a time on a valid/ready stream.
//
// Ports:
//   clk, rst               clock, async active-high reset
//   sa_done                array completion level (rows valid while high)
//   local_buffer_C0..C3    result rows, [127:96]=col0 .. [31:0]=col3
//   ss_tvalid/tready/tdata/tlast   result stream
//   drain_busy             tile held or streaming
//   drain_done             1-cycle pulse after the last beat handshakes
//   overrun, overrun_clr   sticky "new tile arrived while busy" flag + clear
//
// Build option: define SA_DRAIN_COLMAJOR_EN for column-major beat order
// (beat = 4*col + row); default is row-major (beat = 4*row + col).

module sa_result_drain #(
  parameter int DATA_BITS  = 32,
  parameter int DATAC_BITS = 128,
  parameter int NUM_WORDS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sa_done,
  input  logic [DATAC_BITS-1:0] local_buffer_C0,
  input  logic [DATAC_BITS-1:0] local_buffer_C1,
  input  logic [DATAC_BITS-1:0] local_buffer_C2,
  input  logic [DATAC_BITS-1:0] local_buffer_C3,
  output logic                  ss_tvalid,
  input  logic                  ss_tready,
  output logic [DATA_BITS-1:0]  ss_tdata,
  output logic                  ss_tlast,
  output logic                  drain_busy,
  output logic                  drain_done,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int BUF_BITS = 4 * DATAC_BITS;
  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t               state_q, state_d;
  logic                 done_q;
  logic [BUF_BITS-1:0]  buf_q, buf_d;
  logic [3:0]           idx_q, idx_d;
  logic                 ddone_q, ddone_d;
  logic                 ovr_q, ovr_d;

  logic                 rise;
  logic                 streaming;
  logic                 hs;
  logic [3:0]           pos;
  logic [8:0]           bit_base;
  logic [DATA_BITS-1:0] word;

  assign rise      = sa_done & ~done_q;
  assign streaming = (state_q == S_STREAM);
  assign hs        = streaming & ss_tready;

  // Buffer holds {C0,C1,C2,C3}; row-major position p lives at
  // bits [511-32p -: 32], i.e. base index {~p, 5'b0}.
`ifdef SA_DRAIN_COLMAJOR_EN
  assign pos = {idx_q[1:0], idx_q[3:2]};
`else
  assign pos = idx_q;
`endif

  assign bit_base = {~pos, 5'b00000};
  assign word     = buf_q[bit_base +: DATA_BITS];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      buf_q   <= '0;
      idx_q   <= '0;
      ddone_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= sa_done;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      ddone_q <= ddone_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    ddone_d = 1'b0;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          buf_d   = {local_buffer_C0, local_buffer_C1,
                     local_buffer_C2, local_buffer_C3};
          idx_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            ddone_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new tile while one is still held is dropped; set beats clear.
    if (rise && streaming) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    ss_tvalid  = streaming;
    drain_busy = streaming;
    ss_tlast   = streaming && (idx_q == LAST_IDX);
    ss_tdata   = streaming ? word : '0;
  end

  assign drain_done = ddone_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// tb_sa_result_drain: randomized + directed bench for sa_result_drain,
// checked each cycle against a tile-level reference model.

module tb_sa_result_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         sa_done;
  logic [127:0] rows [4];
  logic         ss_tvalid;
  logic         ss_tready;
  logic [31:0]  ss_tdata;
  logic         ss_tlast;
  logic         drain_busy;
  logic         drain_done;
  logic         overrun;
  logic         overrun_clr;

  sa_result_drain dut (
    .clk             (clk),
    .rst             (rst),
    .sa_done         (sa_done),
    .local_buffer_C0 (rows[0]),
    .local_buffer_C1 (rows[1]),
    .local_buffer_C2 (rows[2]),
    .local_buffer_C3 (rows[3]),
    .ss_tvalid       (ss_tvalid),
    .ss_tready       (ss_tready),
    .ss_tdata        (ss_tdata),
    .ss_tlast        (ss_tlast),
    .drain_busy      (drain_busy),
    .drain_done      (drain_done),
    .overrun         (overrun),
    .overrun_clr     (overrun_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  // Expected beat order for a tile whose row-major word k holds value k.
  int co_order [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  function automatic int ord(int i);
`ifdef SA_DRAIN_COLMAJOR_EN
    return co_order[i];
`else
    return i;
`endif
  endfunction

  // Value carried by output beat k, straight from the row inputs.
  function automatic logic [31:0] word_of(int k);
    int r;
    int c;
    logic [127:0] row;
`ifdef SA_DRAIN_COLMAJOR_EN
    r = k % 4;
    c = k / 4;
`else
    r = k / 4;
    c = k % 4;
`endif
    row = rows[r];
    return row[(3 - c) * 32 +: 32];
  endfunction

  // Reference model: a held tile, a count of beats already sent.
  bit          m_busy  = 0;
  logic [31:0] m_words [16];
  int          m_cnt   = 0;
  bit          m_prev  = 0;
  bit          m_ovr   = 0;
  bit          m_pulse = 0;

  always @(posedge clk or posedge rst) begin
    bit rise;
    bit was_busy;
    bit set;
    if (rst) begin
      m_busy  = 0;
      m_cnt   = 0;
      m_prev  = 0;
      m_ovr   = 0;
      m_pulse = 0;
      for (int k = 0; k < 16; k++) m_words[k] = '0;
    end else begin
      rise     = sa_done && !m_prev;
      m_prev   = sa_done;
      was_busy = m_busy;
      set      = 0;
      m_pulse  = 0;
      if (was_busy) begin
        if (rise) set = 1;
        if (ss_tready) begin
          m_cnt++;
          if (m_cnt == 16) begin
            m_busy  = 0;
            m_cnt   = 0;
            m_pulse = 1;
          end
        end
      end else if (rise) begin
        for (int k = 0; k < 16; k++) m_words[k] = word_of(k);
        m_cnt  = 0;
        m_busy = 1;
      end
      if (set) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
    end
  end

  logic [31:0] cap [$];
  int          dd_cnt = 0;
  int          v_cnt  = 0;

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    logic [36:0] exp_v;
    logic [36:0] got_v;
    logic [31:0] e_data;
    e_data = m_busy ? m_words[m_cnt] : 32'h0;
    exp_v  = {m_busy, m_busy && (m_cnt == 15), m_busy, m_pulse, m_ovr, e_data};
    got_v  = {ss_tvalid, ss_tlast, drain_busy, drain_done, overrun, ss_tdata};
    check("cycle{valid,last,busy,done,ovr,data}", 64'(got_v), 64'(exp_v));
    if (ss_tvalid && ss_tready) cap.push_back(ss_tdata);
    if (drain_done) dd_cnt++;
    if (ss_tvalid) v_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int base);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        rows[r][(3 - c) * 32 +: 32] = 32'(base + 4 * r + c);
  endtask

  task automatic pulse();
    sa_done = 1'b1;
    tick();
    sa_done = 1'b0;
  endtask

  task automatic wait_dd(int maxc);
    int n;
    n = 0;
    while (!drain_done && n < maxc) begin
      tick();
      n++;
    end
    check("drain_done_timeout", 64'(n < maxc), 64'd1);
  endtask

  task automatic wait_cap(int sz, int maxc);
    int n;
    n = 0;
    while (cap.size() < sz && n < maxc) begin
      tick();
      n++;
    end
    check("beat_wait_timeout", 64'(n < maxc), 64'd1);
  endtask

  task automatic check_tile(string nm, int base, int off);
    check({nm, "_size"}, 64'(cap.size() >= off + 16), 64'd1);
    for (int i = 0; i < 16; i++)
      check({nm, "_beat"}, 64'(cap[off + i]), 64'(base + ord(i)));
  endtask

  initial begin
    int d0;
    int v0;
    rst         = 1'b1;
    sa_done     = 1'b0;
    ss_tready   = 1'b0;
    overrun_clr = 1'b0;
    load(0);
    repeat (3) tick();
    check("reset_valid", 64'(ss_tvalid), 64'd0);
    check("reset_data", 64'(ss_tdata), 64'd0);
    check("reset_ovr", 64'(overrun), 64'd0);
    rst = 1'b0;
    tick();

    // Basic tile, always ready, then a back-to-back tile on drain_done.
    cap.delete();
    d0 = dd_cnt;
    ss_tready = 1'b1;
    pulse();
    check("latency_valid", 64'(ss_tvalid), 64'd1);
    check("first_data", 64'(ss_tdata), 64'd0);
    load(16);
    wait_dd(40);
    sa_done = 1'b1;
    tick();
    sa_done = 1'b0;
    check("b2b_busy", 64'(drain_busy), 64'd1);
    wait_dd(40);
    tick();
    check_tile("t1", 0, 0);
    check_tile("b2b", 16, 16);
    check("t1_dd", 64'(dd_cnt - d0), 64'd2);
    check("t1_idle", 64'(drain_busy), 64'd0);

    // Alternating ready: 31 valid cycles.
    load(0);
    cap.delete();
    ss_tready = 1'b0;
    sa_done = 1'b1;
    tick();
    sa_done = 1'b0;
    v0 = v_cnt;
    ss_tready = 1'b1;
    for (int n = 0; n < 80 && !drain_done; n++) begin
      tick();
      if (!drain_done) ss_tready = ~ss_tready;
    end
    tick();
    check("t2_vcycles", 64'(v_cnt - v0), 64'd31);
    check_tile("t2", 0, 0);
    ss_tready = 1'b1;

    // sa_done held high: one tile only.
    load(48);
    cap.delete();
    d0 = dd_cnt;
    sa_done = 1'b1;
    repeat (40) tick();
    sa_done = 1'b0;
    tick();
    check("t3_beats", 64'(cap.size()), 64'd16);
    check("t3_dd", 64'(dd_cnt - d0), 64'd1);
    check("t3_ovr", 64'(overrun), 64'd0);
    check_tile("t3", 48, 0);

    // New rise mid-stream is dropped and flags overrun.
    load(64);
    cap.delete();
    pulse();
    wait_cap(5, 40);
    load(200);
    pulse();
    check("t4_ovr_set", 64'(overrun), 64'd1);
    wait_dd(40);
    tick();
    check_tile("t4", 64, 0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t4_ovr_clr", 64'(overrun), 64'd0);
    // Set and clear together: set wins.
    load(64);
    pulse();
    tick();
    sa_done = 1'b1;
    overrun_clr = 1'b1;
    tick();
    sa_done = 1'b0;
    overrun_clr = 1'b0;
    check("t4_set_wins", 64'(overrun), 64'd1);
    wait_dd(40);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;

    // Reset mid-stream after beat 7.
    load(80);
    cap.delete();
    pulse();
    wait_cap(8, 40);
    rst = 1'b1;
    #1;
    check("t5_abort_valid", 64'(ss_tvalid), 64'd0);
    d0 = dd_cnt;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("t5_no_dd", 64'(dd_cnt - d0), 64'd0);
    cap.delete();
    load(96);
    pulse();
    wait_dd(40);
    tick();
    check_tile("t5", 96, 0);

    // Randomized traffic, model-checked every cycle.
    for (int n = 0; n < 1500; n++) begin
      ss_tready = ($urandom_range(3) != 0);
      overrun_clr = ($urandom_range(15) == 0);
      if (sa_done) begin
        sa_done = ($urandom_range(2) == 0);
      end else if ($urandom_range(14) == 0) begin
        for (int r = 0; r < 4; r++)
          rows[r] = {$urandom, $urandom, $urandom, $urandom};
        sa_done = 1'b1;
      end
      if ($urandom_range(400) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    sa_done = 1'b0;
    overrun_clr = 1'b0;
    ss_tready = 1'b1;
    repeat (20) tick();
    check("end_idle", 64'(drain_busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
